// File: rtl/tdm_demux_if.sv
// Bundle of the serial receive side and the parallel channel outputs of the TDM demux.
// slave is the demux itself; master is whatever drives the line and consumes the words.
interface tdm_demux_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned W      = 8,
  parameter int unsigned CW     = $clog2(NUM_CH)
);
  logic                en;
  logic                din;
  logic                frame_sync;
  logic [CW-1:0]       ch_sel;
  logic                busy;
  logic [NUM_CH*W-1:0] ch_data;
  logic                frame_valid;
  logic                frame_err;

  modport master (
    output en, din, frame_sync,
    input  ch_sel, busy, ch_data, frame_valid, frame_err
  );

  modport slave (
    input  en, din, frame_sync,
    output ch_sel, busy, ch_data, frame_valid, frame_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: locks to frame_sync, shifts each bit into its channel word
// and publishes all NUM_CH words together when a complete frame has been received.
module tdm_demux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned W      = 8,
  parameter int unsigned CW     = $clog2(NUM_CH)
) (
  input  logic       clk,
  input  logic       rst,
  tdm_demux_if.slave bus
);
  localparam int unsigned BW = $clog2(W);
  localparam int unsigned FW = NUM_CH * W;

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   ch_sel_q, ch_sel_d;
  logic [FW-1:0]   shadow_q, shadow_d;
  logic [FW-1:0]   ch_data_q, ch_data_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [W-1:0]    cur_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      ch_sel_q      <= '0;
      shadow_q      <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      ch_sel_q      <= ch_sel_d;
      shadow_q      <= shadow_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    ch_sel_d      = ch_sel_q;
    shadow_d      = shadow_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    cur_word      = shadow_q[W*ch_sel_q +: W];

    if (bus.en) begin
      // A sync always starts a new frame; the first bit lands at the LSB and is shifted
      // up to the MSB by the remaining W-1 bits of channel 0.
      if (bus.frame_sync) begin
        frame_err_d     = (state_q == StRecv);
        shadow_d[0 +: W] = W'(bus.din);
        bit_cnt_d       = BW'(1);
        ch_sel_d        = '0;
        state_d         = StRecv;
      end else begin
        unique case (state_q)
          StIdle: ;
          StRecv: begin
            shadow_d[W*ch_sel_q +: W] = {cur_word[W-2:0], bus.din};
            if (bit_cnt_q == BW'(W - 1)) begin
              bit_cnt_d = '0;
              if (ch_sel_q == CW'(NUM_CH - 1)) begin
                ch_data_d     = shadow_d;
                frame_valid_d = 1'b1;
                ch_sel_d      = '0;
                state_d       = StIdle;
              end else begin
                ch_sel_d = ch_sel_q + 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  assign bus.ch_sel      = ch_sel_q;
  assign bus.busy        = (state_q == StRecv);
  assign bus.ch_data     = ch_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: stimulus pushes expected frames, a negedge monitor pops
// and compares them whenever frame_valid is seen.
module tb_tdm_demux;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned W      = 8;
  localparam int unsigned CW     = 2;
  localparam int unsigned FW     = NUM_CH * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux_if #(.NUM_CH(NUM_CH), .W(W), .CW(CW)) bus ();

  tdm_demux #(.NUM_CH(NUM_CH), .W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fv_cyc   = 0;
  int prev_fv_cyc = 0;
  int fv_cnt   = 0;
  int err_cnt  = 0;
  logic [FW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every published frame.
  always @(negedge clk) begin
    logic [FW-1:0] e;
    if (bus.frame_valid || bus.frame_err)
      chk("valid_err_exclusive", 64'(bus.frame_valid & bus.frame_err), 64'd0);
    if (bus.frame_err) err_cnt++;
    if (bus.frame_valid) begin
      prev_fv_cyc = fv_cyc;
      fv_cyc      = cyc;
      fv_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_valid got=%0h exp=none", bus.ch_data);
      end else begin
        e = exp_q.pop_front();
        chk("ch_data", 64'(bus.ch_data), 64'(e));
      end
    end
  end

  task automatic tick(input logic e, input logic d, input logic fs);
    bus.en         = e;
    bus.din        = d;
    bus.frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic stall(input int len);
    for (int j = 0; j < len; j++) tick(1'b0, j[0], j[1]);
  endtask

  task automatic send_partial(input logic [FW-1:0] data, input int nbits);
    for (int k = 0; k < nbits; k++)
      tick(1'b1, data[(k / W) * W + (W - 1 - k % W)], k == 0);
  endtask

  // Full frame, sync on bit 0, optional stalls inserted before bit s1_at / s2_at.
  task automatic send_frame(input logic [FW-1:0] data, input int s1_at, input int s1_len,
                            input int s2_at, input int s2_len, input logic exp_err,
                            output int sync_cyc);
    exp_q.push_back(data);
    sync_cyc = 0;
    for (int k = 0; k < FW; k++) begin
      if (k == s1_at) stall(s1_len);
      if (k == s2_at) stall(s2_len);
      tick(1'b1, data[(k / W) * W + (W - 1 - k % W)], k == 0);
      if (k == 0) begin
        sync_cyc = cyc;
        chk("frame_err_at_sync", 64'(bus.frame_err), 64'(exp_err));
      end
      chk("ch_sel", 64'(bus.ch_sel), (k == FW - 1) ? 64'd0 : 64'((k + 1) / W));
      chk("busy", 64'(bus.busy), (k == FW - 1) ? 64'd0 : 64'd1);
    end
  endtask

  initial begin
    int s;
    int fv0;
    int err0;
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    chk("rst_ch_data", 64'(bus.ch_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ch_sel", 64'(bus.ch_sel), 64'd0);
    chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
    chk("rst_frame_err", 64'(bus.frame_err), 64'd0);
    tick(1'b0, 1'b0, 1'b0);

    // 1: single frame A5,3C,0F,F0
    fv0 = fv_cnt;
    send_frame(32'hF00F3CA5, -1, 0, -1, 0, 1'b0, s);
    tick(1'b0, 1'b0, 1'b0);
    chk("s1_latency", 64'(fv_cyc - s), 64'd31);
    chk("s1_fv_count", 64'(fv_cnt - fv0), 64'd1);
    chk("s1_busy_after", 64'(bus.busy), 64'd0);

    // 2: back-to-back frames
    err0 = err_cnt;
    send_frame(32'h44332211, -1, 0, -1, 0, 1'b0, s);
    send_frame(32'h88776655, -1, 0, -1, 0, 1'b0, s);
    tick(1'b0, 1'b0, 1'b0);
    chk("s2_spacing", 64'(fv_cyc - prev_fv_cyc), 64'd32);
    chk("s2_no_err", 64'(err_cnt - err0), 64'd0);

    // 3: sync reasserted at bit 13, then DE,AD,BE,EF
    err0 = err_cnt;
    fv0  = fv_cnt;
    send_partial(32'h12345678, 13);
    send_frame(32'hEFBEADDE, -1, 0, -1, 0, 1'b1, s);
    tick(1'b0, 1'b0, 1'b0);
    chk("s3_err_count", 64'(err_cnt - err0), 64'd1);
    chk("s3_fv_count", 64'(fv_cnt - fv0), 64'd1);

    // 4: stalls of 5 at bit 7 and 3 at bit 24
    send_frame(32'hF00F3CA5, 7, 5, 24, 3, 1'b0, s);
    tick(1'b0, 1'b0, 1'b0);
    chk("s4_latency", 64'(fv_cyc - s), 64'd39);

    // 5: reset at bit 20, then 01,02,03,04
    send_partial(32'hAABBCCDD, 20);
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("s5_ch_data", 64'(bus.ch_data), 64'd0);
    chk("s5_busy", 64'(bus.busy), 64'd0);
    chk("s5_ch_sel", 64'(bus.ch_sel), 64'd0);
    chk("s5_frame_valid", 64'(bus.frame_valid), 64'd0);
    send_frame(32'h04030201, -1, 0, -1, 0, 1'b0, s);
    tick(1'b0, 1'b0, 1'b0);
    chk("s5_latency", 64'(fv_cyc - s), 64'd31);

    // 6: idle line noise without sync
    fv0  = fv_cnt;
    err0 = err_cnt;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, k[0] ^ k[2], 1'b0);
      chk("s6_busy", 64'(bus.busy), 64'd0);
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("s6_fv_count", 64'(fv_cnt - fv0), 64'd0);
    chk("s6_err_count", 64'(err_cnt - err0), 64'd0);
    chk("s6_ch_data", 64'(bus.ch_data), 64'h04030201);

    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
